// File: rtl/button_pkg.sv
// Shared constants and types for the button event path.
// Defaults match the standard 4-button, 8-deep configuration.
package button_pkg;

  localparam int NUM_BUTTONS_DEF = 4;
  localparam int DEPTH_DEF       = 8;

  // Index width for a given button count; a single button still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BTN_IDX_W = idx_w(NUM_BUTTONS_DEF);

  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/button_event_fifo_if.sv
// Strobe-in / event-out bundle between the edge detectors, the event queue and game logic.
// master = the event queue, slave = its environment (strobe source and consumer).
interface button_event_fifo_if #(
  parameter int NUM_BUTTONS = button_pkg::NUM_BUTTONS_DEF,
  parameter int DEPTH       = button_pkg::DEPTH_DEF
);
  import button_pkg::*;

  logic [NUM_BUTTONS-1:0]             strobe_i;
  logic [idx_w(NUM_BUTTONS)-1:0]      event_o;
  logic                               valid_o;
  logic                               ready_i;
  logic [$clog2(DEPTH+1)-1:0]         count_o;
  logic                               overflow_o;
  logic                               clr_ovf_i;

  modport master (
    input  strobe_i, ready_i, clr_ovf_i,
    output event_o, valid_o, count_o, overflow_o
  );

  modport slave (
    output strobe_i, ready_i, clr_ovf_i,
    input  event_o, valid_o, count_o, overflow_o
  );

endinterface

// File: rtl/button_event_fifo_sync_fifo.sv
// First-word-fall-through FIFO with wrapping pointers and a separate occupancy count.
// Push is accepted when not full or when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_fifo.sv
// Collects per-button press strobes into a pending register, encodes them lowest index first
// and queues them for game logic; presses are only lost when a button re-strobes while still pending.
module button_event_fifo
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  button_event_fifo_if.master bus
);

  localparam int IDX_W = idx_w(NUM_BUTTONS);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NUM_BUTTONS-1:0] pend;
  logic [NUM_BUTTONS-1:0] grant;
  logic [NUM_BUTTONS-1:0] enq_mask;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_pend;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   overflow;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [IDX_W-1:0]       fifo_head;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign any_pend = |pend;
  assign pop      = bus.ready_i & ~fifo_empty;
  assign push     = any_pend & (~fifo_full | pop);
  assign enq_mask = push ? grant : '0;

  // A re-strobe of a bit that is not leaving this cycle merges into the existing press.
  assign drop = |(bus.strobe_i & pend & ~enq_mask);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~enq_mask) | bus.strobe_i;
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .wdata (grant_idx),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.event_o    = fifo_head;
  assign bus.valid_o    = ~fifo_empty;
  assign bus.count_o    = fifo_count;
  assign bus.overflow_o = overflow;

endmodule
